mem_port_arbiter: RTL

//  Shares the CPU's single MMU port between instruction fetch (IF) and the data stage (MEM).

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates the single MMU port between instruction fetch and the data stage
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int MEM_STARVE_LIMIT = 4,
  parameter int CNT_WIDTH        = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        if_error,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic        mem_signed,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  input  logic        mmu_mem_ready,
  input  logic [31:0] mmu_data_out,
  output logic        mmu_read_enable,
  output logic        mmu_write_enable,
  output logic        mmu_mem_signed_read,
  output logic [1:0]  mmu_mem_data_width,
  output logic [31:0] mmu_address,
  output logic [31:0] mmu_data_in
);

  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;
  localparam int SW = $clog2(MEM_STARVE_LIMIT + 1);
  localparam logic [SW-1:0]        STARVE_MAX = SW'(MEM_STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] TCNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

  state_t              state, state_nxt;
  logic [CNT_WIDTH-1:0] tcnt;
  logic [SW-1:0]        starve_cnt;
  logic                 resp_mem;
  logic                 if_flushed;
  logic                 grant_if, grant_mem;
  logic                 if_misaligned, mem_misaligned;
  logic                 timeout_hit;

  assign if_misaligned  = |if_addr[1:0];
  assign mem_misaligned = ((mem_width == WIDTH_WORD) && (|mem_addr[1:0])) ||
                          ((mem_width == WIDTH_HALF) && mem_addr[0]);
  assign timeout_hit    = (tcnt == TCNT_LAST);

  // MEM wins by default; IF takes the port once MEM has starved it long enough
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state == IDLE) begin
      if (if_req && !if_flush && (!mem_req || starve_cnt == STARVE_MAX)) begin
        grant_if = 1'b1;
      end else if (mem_req) begin
        grant_mem = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_if) begin
          state_nxt = if_misaligned ? RESP : BUSY_IF;
        end else if (grant_mem) begin
          state_nxt = mem_misaligned ? RESP : BUSY_MEM;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (mmu_mem_ready || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (grant_if || !if_req) begin
      starve_cnt <= '0;
    end else if (grant_mem && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt                <= '0;
      resp_mem            <= 1'b0;
      if_flushed          <= 1'b0;
      if_rdata            <= '0;
      if_error            <= 1'b0;
      mem_rdata           <= '0;
      mem_error           <= 1'b0;
      mmu_read_enable     <= 1'b0;
      mmu_write_enable    <= 1'b0;
      mmu_mem_signed_read <= 1'b0;
      mmu_mem_data_width  <= '0;
      mmu_address         <= '0;
      mmu_data_in         <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (grant_if) begin
            resp_mem   <= 1'b0;
            if_flushed <= 1'b0;
            if (if_misaligned) begin
              if_error <= 1'b1;
            end else begin
              mmu_read_enable     <= 1'b1;
              mmu_write_enable    <= 1'b0;
              mmu_mem_signed_read <= 1'b0;
              mmu_mem_data_width  <= WIDTH_WORD;
              mmu_address         <= if_addr;
              mmu_data_in         <= '0;
            end
          end else if (grant_mem) begin
            resp_mem <= 1'b1;
            if (mem_misaligned) begin
              mem_error <= 1'b1;
            end else begin
              mmu_read_enable     <= !mem_write;
              mmu_write_enable    <= mem_write;
              mmu_mem_signed_read <= mem_signed;
              mmu_mem_data_width  <= mem_width;
              mmu_address         <= mem_addr;
              mmu_data_in         <= mem_wdata;
            end
          end
        end
        BUSY_IF, BUSY_MEM: begin
          // a flushed fetch still runs to completion; only its response is hidden
          if (state == BUSY_IF && if_flush) begin
            if_flushed <= 1'b1;
          end
          if (mmu_mem_ready) begin
            mmu_read_enable  <= 1'b0;
            mmu_write_enable <= 1'b0;
            if (state == BUSY_MEM) begin
              mem_rdata <= mmu_data_out;
              mem_error <= 1'b0;
            end else begin
              if_rdata <= mmu_data_out;
              if_error <= 1'b0;
            end
          end else if (timeout_hit) begin
            mmu_read_enable  <= 1'b0;
            mmu_write_enable <= 1'b0;
            if (state == BUSY_MEM) begin
              mem_error <= 1'b1;
            end else begin
              if_error <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          tcnt <= '0;
        end
      endcase
    end
  end

  assign mem_ready = (state == RESP) && resp_mem;
  assign if_ready  = (state == RESP) && !resp_mem && !if_flushed && !if_flush;

endmodule
